rr_arb_requester: RTL and testbench
===================================

// Module: rr_arb_requester
// PURPOSE
//   Client-side counterpart of the round-robin arbiter: per-client request queues.
//   Converts per-client push pulses into the arbiter request vector and retires requests on grant.
//   Holds each request bit stable until granted, which is the contract the arbiter expects.
//   Checks grant legality and bounded wait; raises sticky error flags.
// PARAMETERS
//   CLIENTS   32  number of clients; must match the arbiter's CLIENTS
//   CNT_W     4   per-client pending-count width; max pending = 2**CNT_W-1
//   MAX_WAIT  31  max non-stalled cycles a request may wait before starve flags (CLIENTS-1)
// PORTS
//   clock      in   1        single clock; all state updates on posedge
//   reset      in   1        synchronous, active-high reset
//   push       in   CLIENTS  push[i]=1 adds one pending request for client i this cycle
//   grant      in   CLIENTS  grant vector from the arbiter
//   stall      in   1        arbiter stall; wait counters freeze while high
//   request    out  CLIENTS  request vector to the arbiter; request[i] = (pend_cnt[i] != 0)
//   full       out  CLIENTS  full[i] = (pend_cnt[i] == 2**CNT_W-1)
//   overflow   out  CLIENTS  sticky: push[i] seen while full[i] and not retiring
//   starve     out  CLIENTS  sticky: client i waited > MAX_WAIT non-stalled cycles
//   grant_err  out  1        sticky: grant not one-hot-or-zero, or grant[i] without request[i]
// BEHAVIOUR
//   Reset: all pend_cnt and wait_cnt = 0; request, full, overflow, starve, grant_err = 0.
//   Retire: ret[i] = grant[i] & request[i]; grant[i] with request[i]=0 never decrements.
//   pend_cnt update per client, one cycle latency:
//     push & !ret -> +1 (if full: hold value, set overflow[i]); !push & ret -> -1;
//     push & ret -> unchanged (legal even when full); neither -> unchanged.
//   Latency: push at cycle t with count 0 -> request high at t+1.
//   Grant at t with count 1 and no push -> request low at t+1; count >1 keeps request high.
//   Request stability: request[i] never falls while count>0; it only falls after a retiring grant.
//   wait_cnt[i] (width clog2(MAX_WAIT+2), saturating):
//     cleared to 0 when ret[i] or request[i]=0; held when stall=1;
//     else incremented while request[i]=1.
//   starve[i] sets when wait_cnt[i] == MAX_WAIT and the increment condition holds.
//   starve[i] never clears except by reset.
//   grant_err sets when $onehot0(grant)=0 or |(grant & ~request); evaluated every cycle, stall ignored.
//   Sticky flags update with one-cycle latency (visible the cycle after the event).
//   Reset mid-operation: all pending requests discarded; request drops the cycle after reset asserts.
//   Push/grant during reset are ignored.
//   Width rules: counters unsigned; no wrap on pend_cnt (saturate + overflow); wait_cnt saturates.
// STRUCTURE
//   Package rr_arb_pkg: CLIENTS_DEF, CNT_W_DEF, MAX_WAIT_DEF constants.
//   Package rr_arb_pkg also holds typedef client_vec_t = logic [CLIENTS-1:0], shared with rr_arbiter.
//   Sub-module rr_arb_client_slot: one client's pend_cnt, wait_cnt, full, overflow and starve.
//   Top generates CLIENTS slots and adds the global grant_err checker.
//   Embedded SVA, clocked @(posedge clock), disabled iff (reset):
//     assert request[i] && !grant[i] |=> request[i]
//     assert !request[i] |-> wait_cnt[i]==0
// TESTING
//   1 Push client 4 once at t0; grant[4] at t3 -> request[4] high t1..t3, low t4, count 0.
//   2 Push client 7 three times, grant each in turn -> request[7] high until the 3rd grant retires.
//   3 Fill client 0 to 15, push again -> full[0]=1, overflow[0]=1, count stays 15.
//   3 (cont.) Push+grant together while full -> count stays 15, no new overflow.
//   4 Grant 0x3 (two-hot), later grant[9] with request[9]=0 -> grant_err=1 next cycle and stays set.
//   4 (cont.) Count for client 9 unchanged.
//   5 Request client 2 held, no grant, stall=0 -> starve[2] after 32 cycles.
//   5 (cont.) With stall high for 10 of those cycles -> starve[2] after 42 cycles.
//   6 Pending on clients 1,5,31, then assert reset one cycle -> request=0 next cycle.
//   6 (cont.) All flags 0; pushes resume normally after reset.

Source files
------------

// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : rr_arb_pkg
// Purpose: Shared constants and types for the round-robin arbiter and its
//          client-side requester (default client count, pending-count width,
//          starvation bound, and the client bit-vector type).
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package rr_arb_pkg;

  localparam int CLIENTS_DEF  = 32;
  localparam int CNT_W_DEF    = 4;
  localparam int MAX_WAIT_DEF = 31;

  // One bit per client; shared with rr_arbiter so both ends agree on width.
  typedef logic [CLIENTS_DEF-1:0] client_vec_t;

endpackage : rr_arb_pkg
`default_nettype wire

// File: rtl/rr_arb_requester_if.sv
`default_nettype none
// ============================================================================
// Module : rr_arb_requester_if
// Purpose: Bundle of the requester <-> arbiter/client signals.
// Ports  : push, grant, stall      -> into the requester
//          request, full, overflow,
//          starve, grant_err       <- out of the requester
//          modport slave  : requester view
//          modport master : driver/observer view (clients + arbiter side)
// Rev    : 1.0  initial release
// ============================================================================
interface rr_arb_requester_if
  import rr_arb_pkg::*;
#(
  parameter int CLIENTS = CLIENTS_DEF
) ();

  logic [CLIENTS-1:0] push;
  logic [CLIENTS-1:0] grant;
  logic               stall;
  logic [CLIENTS-1:0] request;
  logic [CLIENTS-1:0] full;
  logic [CLIENTS-1:0] overflow;
  logic [CLIENTS-1:0] starve;
  logic               grant_err;

  modport slave (
    input  push, grant, stall,
    output request, full, overflow, starve, grant_err
  );

  modport master (
    output push, grant, stall,
    input  request, full, overflow, starve, grant_err
  );

endinterface : rr_arb_requester_if
`default_nettype wire

// File: rtl/rr_arb_client_slot.sv
`default_nettype none
// ============================================================================
// Module : rr_arb_client_slot
// Purpose: State for one client: saturating pending-request counter, wait
//          counter, and sticky overflow / starvation flags.
// Ports  : clock, reset         clock and synchronous active-high reset
//          push                 add one pending request
//          grant                this client's grant bit from the arbiter
//          stall                arbiter stall, freezes the wait counter
//          request              pending count non-zero
//          full                 pending count at maximum
//          overflow             sticky: push dropped because full
//          starve               sticky: waited beyond MAX_WAIT cycles
// Rev    : 1.0  initial release
// ============================================================================
module rr_arb_client_slot
  import rr_arb_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic push,
  input  wire logic grant,
  input  wire logic stall,
  output logic      request,
  output logic      full,
  output logic      overflow,
  output logic      starve
);

  localparam int                WAIT_W       = $clog2(MAX_WAIT + 2);
  localparam logic [CNT_W-1:0]  C_CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  C_CNT_ONE    = CNT_W'(1);
  localparam logic [WAIT_W-1:0] C_WAIT_MAX   = '1;
  localparam logic [WAIT_W-1:0] C_WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] C_WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  r_pend_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_overflow;
  logic              r_starve;

  logic [CNT_W-1:0]  w_pend_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_ret;
  logic              w_wait_inc;
  logic              w_ovf_set;
  logic              w_starve_set;

  assign request = (r_pend_cnt != '0);
  assign full    = (r_pend_cnt == C_CNT_MAX);

  // A grant only retires something if a request is actually outstanding.
  assign w_ret      = grant & request;
  assign w_wait_inc = request & ~w_ret & ~stall;

  always_comb begin
    w_pend_nxt = r_pend_cnt;
    w_ovf_set  = 1'b0;
    if (push && !w_ret) begin
      if (full) begin
        w_ovf_set = 1'b1;             // saturate instead of wrapping
      end else begin
        w_pend_nxt = r_pend_cnt + C_CNT_ONE;
      end
    end else if (!push && w_ret) begin
      w_pend_nxt = r_pend_cnt - C_CNT_ONE;
    end
    // push & ret: one in, one out -> unchanged, even when full
  end

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!request || w_ret) begin
      w_wait_nxt = '0;
    end else if (!stall && (r_wait_cnt != C_WAIT_MAX)) begin
      w_wait_nxt = r_wait_cnt + C_WAIT_ONE;
    end
  end

  assign w_starve_set = w_wait_inc && (r_wait_cnt == C_WAIT_LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend_cnt <= '0;
      r_wait_cnt <= '0;
      r_overflow <= 1'b0;
      r_starve   <= 1'b0;
    end else begin
      r_pend_cnt <= w_pend_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_ovf_set)    r_overflow <= 1'b1;
      if (w_starve_set) r_starve   <= 1'b1;
    end
  end

  assign overflow = r_overflow;
  assign starve   = r_starve;

  // An ungranted request must stay up: the arbiter relies on it.
  a_req_hold : assert property (@(posedge clock) disable iff (reset)
    request && !grant |=> request);

  a_wait_idle : assert property (@(posedge clock) disable iff (reset)
    !request |-> (r_wait_cnt == '0));

endmodule : rr_arb_client_slot
`default_nettype wire

// File: rtl/rr_arb_requester.sv
`default_nettype none
// ============================================================================
// Module : rr_arb_requester
// Purpose: Client-side counterpart of the round-robin arbiter. Turns per-client
//          push pulses into a stable request vector, retires requests on grant
//          and flags overflow, starvation and illegal grants (all sticky).
// Ports  : clock, reset   clock and synchronous active-high reset
//          bus (slave)    push/grant/stall in; request/full/overflow/
//                         starve/grant_err out
// Rev    : 1.0  initial release
// ============================================================================
module rr_arb_requester
  import rr_arb_pkg::*;
#(
  parameter int CLIENTS  = CLIENTS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input wire logic          clock,
  input wire logic          reset,
  rr_arb_requester_if.slave bus
);

  logic [CLIENTS-1:0] w_request;
  logic [CLIENTS-1:0] w_full;
  logic [CLIENTS-1:0] w_overflow;
  logic [CLIENTS-1:0] w_starve;
  logic               w_grant_bad;
  logic               r_grant_err;

  for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_slot
    rr_arb_client_slot #(
      .CNT_W    (CNT_W),
      .MAX_WAIT (MAX_WAIT)
    ) u_slot (
      .clock    (clock),
      .reset    (reset),
      .push     (bus.push[gi]),
      .grant    (bus.grant[gi]),
      .stall    (bus.stall),
      .request  (w_request[gi]),
      .full     (w_full[gi]),
      .overflow (w_overflow[gi]),
      .starve   (w_starve[gi])
    );
  end

  // Grant legality is checked regardless of stall.
  assign w_grant_bad = !$onehot0(bus.grant) || (|(bus.grant & ~w_request));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_grant_err <= 1'b0;
    end else if (w_grant_bad) begin
      r_grant_err <= 1'b1;
    end
  end

  assign bus.request   = w_request;
  assign bus.full      = w_full;
  assign bus.overflow  = w_overflow;
  assign bus.starve    = w_starve;
  assign bus.grant_err = r_grant_err;

endmodule : rr_arb_requester
`default_nettype wire

// File: tb/tb_rr_arb_requester.sv
`default_nettype none
// ============================================================================
// Module : tb_rr_arb_requester
// Purpose: Self-checking bench for rr_arb_requester: directed vector table,
//          hand-written corner sequences and randomized traffic compared
//          against an integer reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rr_arb_requester;
  import rr_arb_pkg::*;

  localparam int N     = CLIENTS_DEF;
  localparam int PMAX  = (1 << CNT_W_DEF) - 1;
  localparam int WSAT  = (1 << $clog2(MAX_WAIT_DEF + 2)) - 1;

  logic clock;
  logic reset;

  rr_arb_requester_if #(.CLIENTS(N)) bus ();

  rr_arb_requester #(
    .CLIENTS  (N),
    .CNT_W    (CNT_W_DEF),
    .MAX_WAIT (MAX_WAIT_DEF)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: plain integer counts per client.
  int          m_pend [N];
  int          m_wait [N];
  client_vec_t m_ovf;
  client_vec_t m_starve;
  logic        m_err;

  function automatic client_vec_t model_req();
    client_vec_t v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_pend[i] > 0);
    return v;
  endfunction

  function automatic client_vec_t model_full();
    client_vec_t v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_pend[i] == PMAX);
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_wait[i] = 0;
    end
    m_ovf = '0; m_starve = '0; m_err = 1'b0;
  endfunction

  function automatic void model_step(client_vec_t p, client_vec_t g, logic s, logic r);
    client_vec_t req;
    logic ret;
    if (r) begin
      model_clear();
      return;
    end
    req = model_req();
    if ($countones(g) > 1 || (g & ~req) != '0) m_err = 1'b1;
    for (int i = 0; i < N; i++) begin
      ret = g[i] && req[i];
      if (p[i] && !ret) begin
        if (m_pend[i] == PMAX) m_ovf[i] = 1'b1;
        else m_pend[i] = m_pend[i] + 1;
      end else if (!p[i] && ret) begin
        m_pend[i] = m_pend[i] - 1;
      end
      if (!req[i] || ret) begin
        m_wait[i] = 0;
      end else if (!s) begin
        if (m_wait[i] == MAX_WAIT_DEF) m_starve[i] = 1'b1;
        if (m_wait[i] < WSAT) m_wait[i] = m_wait[i] + 1;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("m_request",   bus.request,           model_req());
    check("m_full",      bus.full,              model_full());
    check("m_overflow",  bus.overflow,          m_ovf);
    check("m_starve",    bus.starve,            m_starve);
    check("m_grant_err", {31'b0, bus.grant_err}, {31'b0, m_err});
  endtask

  // Drive one cycle away from the edge, update the model at the edge, sample after it.
  task automatic step(input client_vec_t p, input client_vec_t g, input logic s, input logic r);
    @(negedge clock);
    bus.push = p; bus.grant = g; bus.stall = s; reset = r;
    @(posedge clock);
    model_step(p, g, s, r);
    #1;
    check_model();
  endtask

  typedef struct {
    client_vec_t push;
    client_vec_t grant;
    logic        stall;
    client_vec_t exp_req;
    logic        exp_err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int n;
    int r;
    int start;
    client_vec_t p, g, req;
    logic s, rs;

    bus.push = '0; bus.grant = '0; bus.stall = 1'b0; reset = 1'b1;
    model_clear();

    // Table: single request on client 4, then three queued on client 7.
    tbl[0] = '{32'h0000_0010, 32'h0, 1'b0, 32'h0000_0010, 1'b0};
    tbl[1] = '{32'h0,         32'h0, 1'b0, 32'h0000_0010, 1'b0};
    tbl[2] = '{32'h0,         32'h0, 1'b0, 32'h0000_0010, 1'b0};
    tbl[3] = '{32'h0, 32'h0000_0010, 1'b0, 32'h0,         1'b0};
    tbl[4] = '{32'h0000_0080, 32'h0, 1'b0, 32'h0000_0080, 1'b0};
    tbl[5] = '{32'h0000_0080, 32'h0, 1'b1, 32'h0000_0080, 1'b0};
    tbl[6] = '{32'h0000_0080, 32'h0, 1'b0, 32'h0000_0080, 1'b0};
    tbl[7] = '{32'h0, 32'h0000_0080, 1'b0, 32'h0000_0080, 1'b0};
    tbl[8] = '{32'h0, 32'h0000_0080, 1'b0, 32'h0000_0080, 1'b0};
    tbl[9] = '{32'h0, 32'h0000_0080, 1'b0, 32'h0,         1'b0};

    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    check("rst_request",  bus.request,  32'h0);
    check("rst_full",     bus.full,     32'h0);
    check("rst_overflow", bus.overflow, 32'h0);
    check("rst_starve",   bus.starve,   32'h0);
    check("rst_err",      {31'b0, bus.grant_err}, 32'h0);

    for (int k = 0; k < 10; k++) begin
      step(tbl[k].push, tbl[k].grant, tbl[k].stall, 1'b0);
      check($sformatf("tbl%0d_req", k), bus.request, tbl[k].exp_req);
      check($sformatf("tbl%0d_err", k), {31'b0, bus.grant_err}, {31'b0, tbl[k].exp_err});
    end

    // Saturation on client 0; push+grant while full is a legal no-op.
    step('0, '0, 1'b0, 1'b1);
    for (int k = 0; k < PMAX; k++) step(32'h1, '0, 1'b0, 1'b0);
    check("fill_full", {31'b0, bus.full[0]}, 32'h1);
    check("fill_ovf",  {31'b0, bus.overflow[0]}, 32'h0);
    step(32'h1, 32'h1, 1'b0, 1'b0);
    check("pg_full",   {31'b0, bus.full[0]}, 32'h1);
    check("pg_ovf",    {31'b0, bus.overflow[0]}, 32'h0);
    step(32'h1, '0, 1'b0, 1'b0);
    check("ovf_set",   {31'b0, bus.overflow[0]}, 32'h1);
    check("ovf_full",  {31'b0, bus.full[0]}, 32'h1);
    step('0, 32'h1, 1'b0, 1'b0);
    check("drain_full", {31'b0, bus.full[0]}, 32'h0);
    check("ovf_sticky", {31'b0, bus.overflow[0]}, 32'h1);

    // Illegal grants: two-hot, then grant without request.
    step('0, '0, 1'b0, 1'b1);
    step(32'h3, '0, 1'b0, 1'b0);
    step('0, 32'h3, 1'b0, 1'b0);
    check("twohot_err", {31'b0, bus.grant_err}, 32'h1);
    step('0, '0, 1'b0, 1'b0);
    check("twohot_sticky", {31'b0, bus.grant_err}, 32'h1);
    step('0, '0, 1'b0, 1'b1);
    check("err_cleared", {31'b0, bus.grant_err}, 32'h0);
    step('0, 32'h0000_0200, 1'b0, 1'b0);
    check("noreq_err", {31'b0, bus.grant_err}, 32'h1);
    check("noreq_cnt", {31'b0, bus.request[9]}, 32'h0);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    check("noreq_sticky", {31'b0, bus.grant_err}, 32'h1);
    check("noreq_cnt2",   {31'b0, bus.request[9]}, 32'h0);

    // Starvation latency without and with stall.
    step('0, '0, 1'b0, 1'b1);
    step(32'h4, '0, 1'b0, 1'b0);
    n = 0;
    while (!bus.starve[2] && n < 100) begin
      step('0, '0, 1'b0, 1'b0);
      n++;
    end
    check("starve_lat", 32'(n), 32'd32);
    step('0, '0, 1'b0, 1'b1);
    step(32'h4, '0, 1'b0, 1'b0);
    n = 0;
    while (!bus.starve[2] && n < 100) begin
      step('0, '0, (n < 10), 1'b0);
      n++;
    end
    check("starve_stall_lat", 32'(n), 32'd42);

    // Reset mid-operation.
    step('0, '0, 1'b0, 1'b1);
    step(32'h8000_0022, '0, 1'b0, 1'b0);
    check("pre_rst_req", bus.request, 32'h8000_0022);
    step('0, '0, 1'b0, 1'b1);
    check("mid_rst_req", bus.request, 32'h0);
    check("mid_rst_flags", bus.overflow | bus.starve | bus.full, 32'h0);
    step(32'h0000_0020, '0, 1'b0, 1'b0);
    check("post_rst_req", bus.request, 32'h0000_0020);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      p = client_vec_t'($urandom & $urandom & $urandom);
      req = model_req();
      g = '0;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        start = $urandom_range(0, N - 1);
        for (int k = 0; k < N; k++) begin
          if (g == '0 && req[(start + k) % N]) g[(start + k) % N] = 1'b1;
        end
      end else if (r == 8) begin
        g[$urandom_range(0, N - 1)] = 1'b1;
      end else if (r == 9) begin
        g[$urandom_range(0, N - 1)] = 1'b1;
        g[$urandom_range(0, N - 1)] = 1'b1;
      end
      s  = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 199) == 0);
      step(p, g, s, rs);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_rr_arb_requester
`default_nettype wire
